// File: rtl/apb_master.sv
// APB master: turns a valid/ready command into one APB SETUP/ACCESS transfer and one response pulse.
// Latency: command accepted at T -> SETUP at T+1 -> ACCESS from T+2 -> rsp_valid one cycle after the last ACCESS.
// Backpressure: cmd_ready is high only in IDLE; the response side has no backpressure (single-cycle pulse).
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_write/cmd_addr/cmd_wdata describe the transfer
//   rsp_valid/rsp_rdata/rsp_err  completion pulse; rdata/err hold until the next completion
//   paddr..pwdata, prdata,       APB requester signals
//   pready, pslverr
module apb_master #(
   parameter int unsigned TIMEOUT = 16   // max ACCESS cycles with pready low before abort (1..255)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t      r_state,     w_state_nxt;
   logic [7:0]  r_wait_cnt,  w_wait_cnt_nxt;
   logic        r_cmd_ready, w_cmd_ready_nxt;
   logic [31:0] r_paddr,     w_paddr_nxt;
   logic        r_psel,      w_psel_nxt;
   logic        r_penable,   w_penable_nxt;
   logic        r_pwrite,    w_pwrite_nxt;
   logic [31:0] r_pwdata,    w_pwdata_nxt;
   logic        r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic        r_rsp_err,   w_rsp_err_nxt;

   always_comb begin
      // Defaults: hold the transfer attributes and response, drop the pulses and APB strobes.
      w_state_nxt     = r_state;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_paddr_nxt     = r_paddr;
      w_pwrite_nxt    = r_pwrite;
      w_pwdata_nxt    = r_pwdata;
      w_psel_nxt      = 1'b0;
      w_penable_nxt   = 1'b0;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;

      case (r_state)
         ST_IDLE: begin
            // r_cmd_ready (not just the state) gates acceptance so nothing is taken
            // in the first cycle after reset, where cmd_ready is still low.
            if (cmd_valid && r_cmd_ready) begin
               w_state_nxt    = ST_SETUP;
               w_wait_cnt_nxt = 8'd0;
               w_paddr_nxt    = cmd_addr;
               w_pwrite_nxt   = cmd_write;
               w_pwdata_nxt   = cmd_wdata;
               w_psel_nxt     = 1'b1;
            end
         end
         ST_SETUP: begin
            w_state_nxt   = ST_ACCESS;
            w_psel_nxt    = 1'b1;
            w_penable_nxt = 1'b1;
         end
         ST_ACCESS: begin
            // pready wins over a timeout reached in the same cycle.
            if (pready) begin
               w_state_nxt     = ST_IDLE;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = pslverr;
               w_rsp_rdata_nxt = r_pwrite ? 32'd0 : prdata;
            end else if (r_wait_cnt == L_TIMEOUT) begin
               w_state_nxt     = ST_IDLE;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_rdata_nxt = 32'd0;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 8'd1;
               w_psel_nxt     = 1'b1;
               w_penable_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= 8'd0;
         r_cmd_ready <= 1'b0;
         r_paddr     <= 32'd0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_paddr     <= w_paddr_nxt;
         r_psel      <= w_psel_nxt;
         r_penable   <= w_penable_nxt;
         r_pwrite    <= w_pwrite_nxt;
         r_pwdata    <= w_pwdata_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign paddr     = r_paddr;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign pwdata    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
